// File: rtl/tick_scheduler.sv
// tick_scheduler: a shared base timebase drives N_CH countdown channels.
// Channel expiries are queued as pending flags and presented one at a time
// through a valid/ack event port, chosen by round-robin. Events lost while
// an earlier one is still pending are recorded as sticky overrun flags.
module tick_scheduler #(
  parameter int PERIOD = 50000,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_load,
  input  logic                    cfg_periodic,
  input  logic                    cfg_start,
  output logic                    tick,
  output logic [N_CH-1:0]         active,
  output logic [N_CH-1:0]         overrun,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  input  logic                    evt_ack
);

  localparam int CH_W = $clog2(N_CH);
  localparam int BW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [BW-1:0] BASE_LAST = BW'(PERIOD - 1);

  typedef enum logic {IDLE, PRESENT} evt_state_e;

  // A count of zero would never expire, so zero loads behave as one.
  function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  logic [BW-1:0]    base_q;
  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [CNT_W-1:0] cnt_d    [N_CH];
  logic [CNT_W-1:0] reload_q [N_CH];
  logic [CNT_W-1:0] reload_d [N_CH];
  logic [N_CH-1:0]  per_q, per_d;
  logic [N_CH-1:0]  active_q, active_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic [N_CH-1:0]  wr_sel, ack_sel, expire;
  evt_state_e       state_q, state_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic             found;
  int               idx;

  assign tick      = en && (base_q == BASE_LAST) && !rst;
  assign active    = active_q;
  assign overrun   = overrun_q;
  assign evt_valid = (state_q == PRESENT);
  assign evt_ch    = evt_ch_q;

  // Base counter: free-runs 0..PERIOD-1 while enabled, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
    end else if (en) begin
      base_q <= (base_q == BASE_LAST) ? '0 : base_q + BW'(1);
    end
  end

  // Decode which channel is being written and which is being acknowledged.
  always_comb begin
    wr_sel  = '0;
    ack_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_sel[c]  = cfg_we && (cfg_ch == CH_W'(c));
      ack_sel[c] = (state_q == PRESENT) && evt_ack && (evt_ch_q == CH_W'(c));
    end
  end

  // Channel next state: a write wins over a tick on the same channel.
  always_comb begin
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    per_d     = per_q;
    active_d  = active_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    expire    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_sel[c]) begin
        if (cfg_start) begin
          cnt_d[c]     = min_one(cfg_load);
          reload_d[c]  = cfg_load;
          per_d[c]     = cfg_periodic;
          active_d[c]  = 1'b1;
          overrun_d[c] = 1'b0;
        end else begin
          active_d[c]  = 1'b0;
        end
      end else if (tick && active_q[c]) begin
        if (cnt_q[c] == CNT_W'(1)) begin
          expire[c] = 1'b1;
          if (per_q[c]) begin
            cnt_d[c] = min_one(reload_q[c]);
          end else begin
            active_d[c] = 1'b0;
          end
        end else begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
      if (ack_sel[c]) begin
        pending_d[c] = 1'b0;
      end
      // An expiry racing an ack of the same channel counts as a fresh event.
      if (expire[c]) begin
        if (pending_q[c] && !ack_sel[c]) begin
          overrun_d[c] = 1'b1;
        end else begin
          pending_d[c] = 1'b1;
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]    <= '0;
        reload_q[c] <= '0;
      end
      per_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      per_q     <= per_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Event FSM: pick the next pending channel after the last grant, hold until acked.
  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    last_d   = last_q;
    found    = 1'b0;
    idx      = 0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = PRESENT;
          for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_q) + i) % N_CH;
            if (!found && pending_q[idx]) begin
              evt_ch_d = CH_W'(idx);
              found    = 1'b1;
            end
          end
        end
      end
      PRESENT: begin
        if (evt_ack) begin
          state_d = IDLE;
          last_d  = evt_ch_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FSM registers; last grant starts at N_CH-1 so channel 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      evt_ch_q <= '0;
      last_q   <= CH_W'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      evt_ch_q <= evt_ch_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PERIOD=4, N_CH=4.
module tb_tick_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_load;
  logic        cfg_periodic;
  logic        cfg_start;
  logic        tick;
  logic [3:0]  active;
  logic [3:0]  overrun;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ack;

  int n_tests;
  int n_fail;
  int cyc;

  tick_scheduler #(.PERIOD(4), .N_CH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_load     (cfg_load),
    .cfg_periodic (cfg_periodic),
    .cfg_start    (cfg_start),
    .tick         (tick),
    .active       (active),
    .overrun      (overrun),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_ack      (evt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; evt_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic arm(input logic [1:0] ch, input logic [15:0] load,
                     input logic periodic, input logic start);
    cfg_we = 1'b1; cfg_ch = ch; cfg_load = load;
    cfg_periodic = periodic; cfg_start = start;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_evt(output int at_cyc, output bit ok);
    int n;
    n = 0;
    while (!evt_valid && n < 100) begin
      step();
      n++;
    end
    ok = evt_valid;
    at_cyc = cyc;
  endtask

  task automatic ack_evt();
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; evt_ack = 1'b0;
    cfg_ch = '0; cfg_load = '0; cfg_periodic = 1'b0; cfg_start = 1'b0;
    #2;
    step();
    step();
    step();
    step();
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_tests++; if (active !== 4'h0) begin n_fail++; $display("FAIL reset_active got %h want 0", active); end
    n_tests++; if (overrun !== 4'h0) begin n_fail++; $display("FAIL reset_overrun got %h want 0", overrun); end
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid got %b want 0", evt_valid); end
    n_tests++; if (evt_ch !== 2'd0) begin n_fail++; $display("FAIL reset_evt_ch got %0d want 0", evt_ch); end
    rst = 1'b0;
  endtask

  task automatic test_tick();
    do_reset();
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_base0 got %b want 0", tick); end
    step(); step(); step();
    n_tests++; if (tick !== 1'b1) begin n_fail++; $display("FAIL tick_base3 got %b want 1", tick); end
    step();
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_wrap got %b want 0", tick); end
  endtask

  task automatic test_oneshot();
    int c0, ce;
    bit ok;
    do_reset();
    arm(2'd0, 16'd3, 1'b0, 1'b1);
    c0 = cyc;
    n_tests++; if (active !== 4'b0001) begin n_fail++; $display("FAIL oneshot_armed got %h want 1", active); end
    wait_evt(ce, ok);
    n_tests++; if (!ok || (ce - c0) != 12) begin n_fail++; $display("FAIL oneshot_latency got %0d want 12", ce - c0); end
    n_tests++; if (evt_ch !== 2'd0) begin n_fail++; $display("FAIL oneshot_ch got %0d want 0", evt_ch); end
    n_tests++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_inactive got %b want 0", active[0]); end
    ack_evt();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack got %b want 0", evt_valid); end
  endtask

  task automatic test_periodic();
    int c0, e1, e2;
    bit ok1, ok2;
    do_reset();
    arm(2'd1, 16'd2, 1'b1, 1'b1);
    c0 = cyc;
    wait_evt(e1, ok1);
    n_tests++; if (!ok1 || (e1 - c0) != 8) begin n_fail++; $display("FAIL periodic_first got %0d want 8", e1 - c0); end
    n_tests++; if (evt_ch !== 2'd1) begin n_fail++; $display("FAIL periodic_ch got %0d want 1", evt_ch); end
    ack_evt();
    wait_evt(e2, ok2);
    n_tests++; if (!ok2 || (e2 - e1) != 8) begin n_fail++; $display("FAIL periodic_spacing got %0d want 8", e2 - e1); end
    n_tests++; if (active[1] !== 1'b1) begin n_fail++; $display("FAIL periodic_active got %b want 1", active[1]); end
    n_tests++; if (overrun[1] !== 1'b0) begin n_fail++; $display("FAIL periodic_overrun got %b want 0", overrun[1]); end
    ack_evt();
  endtask

  task automatic test_round_robin();
    int ce;
    bit ok;
    do_reset();
    arm(2'd0, 16'd1, 1'b0, 1'b1);
    arm(2'd2, 16'd1, 1'b0, 1'b1);
    wait_evt(ce, ok);
    n_tests++; if (!ok || evt_ch !== 2'd0) begin n_fail++; $display("FAIL rr1_first got %0d want 0", evt_ch); end
    ack_evt();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr1_gap got %b want 0", evt_valid); end
    wait_evt(ce, ok);
    n_tests++; if (!ok || evt_ch !== 2'd2) begin n_fail++; $display("FAIL rr1_second got %0d want 2", evt_ch); end
    ack_evt();
    arm(2'd2, 16'd1, 1'b0, 1'b1);
    arm(2'd0, 16'd1, 1'b0, 1'b1);
    wait_evt(ce, ok);
    n_tests++; if (!ok || evt_ch !== 2'd0) begin n_fail++; $display("FAIL rr2_first got %0d want 0", evt_ch); end
    ack_evt();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr2_gap got %b want 0", evt_valid); end
    wait_evt(ce, ok);
    n_tests++; if (!ok || evt_ch !== 2'd2) begin n_fail++; $display("FAIL rr2_second got %0d want 2", evt_ch); end
    ack_evt();
  endtask

  task automatic test_overrun();
    do_reset();
    arm(2'd3, 16'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step();
    n_tests++; if (overrun[3] !== 1'b0) begin n_fail++; $display("FAIL ovr_before got %b want 0", overrun[3]); end
    n_tests++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin n_fail++; $display("FAIL ovr_evt got v=%b ch=%0d want v=1 ch=3", evt_valid, evt_ch); end
    step();
    n_tests++; if (overrun[3] !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun[3]); end
    arm(2'd3, 16'd1, 1'b1, 1'b1);
    n_tests++; if (overrun[3] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun[3]); end
  endtask

  task automatic test_enable_freeze();
    int c0, ce;
    bit ok, saw_tick;
    do_reset();
    arm(2'd0, 16'd3, 1'b0, 1'b1);
    c0 = cyc;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0;
    saw_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tick) saw_tick = 1'b1;
      step();
    end
    n_tests++; if (saw_tick !== 1'b0) begin n_fail++; $display("FAIL freeze_tick got %b want 0", saw_tick); end
    en = 1'b1;
    wait_evt(ce, ok);
    n_tests++; if (!ok || (ce - c0) != 22) begin n_fail++; $display("FAIL freeze_latency got %0d want 22", ce - c0); end
    ack_evt();
  endtask

  task automatic test_reset_mid();
    int ce;
    bit ok, bad;
    do_reset();
    arm(2'd1, 16'd1, 1'b1, 1'b1);
    wait_evt(ce, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_evt got %b want 1", evt_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (evt_valid !== 1'b0 || active !== 4'h0 || overrun !== 4'h0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b act=%h ovr=%h tick=%b want all 0", evt_valid, active, overrun, tick);
    end
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (evt_valid || active != 4'h0) bad = 1'b1;
    end
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b want 0", bad); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    test_reset();
    test_tick();
    test_oneshot();
    test_periodic();
    test_round_robin();
    test_overrun();
    test_enable_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
